// File: rtl/lsb_rs_queue_pkg.sv
// Shared defaults and queue bookkeeping types for the load/store reservation queue.
package lsb_rs_queue_pkg;

  // Default sizes used when the queue is instantiated without overrides.
  localparam int LSB_RS_DEPTH_DEFAULT = 16;
  localparam int CDB_COUNT_DEFAULT    = 4;

  localparam logic VALID   = 1'b1;
  localparam logic INVALID = 1'b0;

  // What the queue does with its occupancy this cycle.
  typedef enum logic [1:0] {
    Q_HOLD     = 2'b00,
    Q_PUSH     = 2'b01,
    Q_POP      = 2'b10,
    Q_PUSH_POP = 2'b11
  } q_action_e;

  function automatic q_action_e q_action(input logic push, input logic pop);
    return q_action_e'({pop, push});
  endfunction

endpackage

// File: rtl/lsb_rs_queue_cdb_match.sv
// Priority match of one operand tag against all CDB channels; channel 0 wins.
module lsb_rs_queue_cdb_match
  import lsb_rs_queue_pkg::*;
#(
  parameter int CDB_CNT = CDB_COUNT_DEFAULT,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32
) (
  input  logic [TAG_W-1:0]          tag,
  input  logic [CDB_CNT-1:0]        cdb_valid,
  input  logic [CDB_CNT*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_CNT*DATA_W-1:0] cdb_data,
  output logic                      hit,
  output logic [DATA_W-1:0]         data
);

  // Scan from the highest channel down so the lowest matching channel is the last writer.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    hit  = INVALID;
    data = '0;
    for (int k = CDB_CNT - 1; k >= 0; k--) begin
      if (cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == tag)) begin
        hit  = VALID;
        data = cdb_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/lsb_rs_queue.sv
// In-order reservation queue feeding the load/store buffer: holds memory ops until
// both operands are known, snoops the CDB (including on the dispatch cycle) and
// issues the head entry through a registered valid/ready stage.
module lsb_rs_queue
  import lsb_rs_queue_pkg::*;
#(
  parameter int DEPTH   = LSB_RS_DEPTH_DEFAULT,
  parameter int CDB_CNT = CDB_COUNT_DEFAULT,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  output logic                      is_full,
  output logic [$clog2(DEPTH):0]    free_cnt,
  input  logic                      dispatch_valid,
  input  logic [OP_W-1:0]           dispatch_op,
  input  logic [DATA_W-1:0]         dispatch_imm,
  input  logic                      dispatch_reg1_valid,
  input  logic [DATA_W-1:0]         dispatch_reg1_data,
  input  logic [TAG_W-1:0]          dispatch_reg1_tag,
  input  logic                      dispatch_reg2_valid,
  input  logic [DATA_W-1:0]         dispatch_reg2_data,
  input  logic [TAG_W-1:0]          dispatch_reg2_tag,
  input  logic [TAG_W-1:0]          dispatch_dest_tag,
  input  logic [CDB_CNT-1:0]        cdb_valid,
  input  logic [CDB_CNT*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_CNT*DATA_W-1:0] cdb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OP_W-1:0]           out_op,
  output logic [DATA_W-1:0]         out_reg1,
  output logic [DATA_W-1:0]         out_reg2,
  output logic [DATA_W-1:0]         out_imm,
  output logic [TAG_W-1:0]          out_dest_tag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm;
    logic              r1_valid;
    logic [DATA_W-1:0] r1_data;
    logic [TAG_W-1:0]  r1_tag;
    logic              r2_valid;
    logic [DATA_W-1:0] r2_data;
    logic [TAG_W-1:0]  r2_tag;
    logic [TAG_W-1:0]  dest;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic              out_valid_q, out_valid_d;
  logic [OP_W-1:0]   out_op_q, out_op_d;
  logic [DATA_W-1:0] out_reg1_q, out_reg1_d;
  logic [DATA_W-1:0] out_reg2_q, out_reg2_d;
  logic [DATA_W-1:0] out_imm_q, out_imm_d;
  logic [TAG_W-1:0]  out_dest_q, out_dest_d;

  logic [DEPTH-1:0]  wk1_hit, wk2_hit;
  logic [DATA_W-1:0] wk1_data [DEPTH];
  logic [DATA_W-1:0] wk2_data [DEPTH];
  logic              byp1_hit, byp2_hit;
  logic [DATA_W-1:0] byp1_data, byp2_data;

  logic              full, head_ready, pop, push;
  entry_t            new_ent;

  // Wakeup matchers: one per stored operand.
  for (genvar i = 0; i < DEPTH; i++) begin : g_wakeup
    lsb_rs_queue_cdb_match #(.CDB_CNT(CDB_CNT), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_match1 (
      .tag(ent_q[i].r1_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .hit(wk1_hit[i]), .data(wk1_data[i])
    );
    lsb_rs_queue_cdb_match #(.CDB_CNT(CDB_CNT), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_match2 (
      .tag(ent_q[i].r2_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .hit(wk2_hit[i]), .data(wk2_data[i])
    );
  end

  // Dispatch bypass matchers, so a result broadcast in the dispatch cycle is not lost.
  lsb_rs_queue_cdb_match #(.CDB_CNT(CDB_CNT), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_byp1 (
    .tag(dispatch_reg1_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .hit(byp1_hit), .data(byp1_data)
  );
  lsb_rs_queue_cdb_match #(.CDB_CNT(CDB_CNT), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_byp2 (
    .tag(dispatch_reg2_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .hit(byp2_hit), .data(byp2_data)
  );

  // Push/pop decisions and the entry image written on a push.
  always_comb begin
    full       = (count_q == CW'(DEPTH));
    head_ready = busy_q[head_q] && ent_q[head_q].r1_valid && ent_q[head_q].r2_valid;
    pop        = head_ready && (!out_valid_q || out_ready);
    // A full queue still accepts a push when the head leaves in the same cycle.
    push       = dispatch_valid && (!full || pop);

    new_ent.op       = dispatch_op;
    new_ent.imm      = dispatch_imm;
    new_ent.r1_tag   = dispatch_reg1_tag;
    new_ent.r2_tag   = dispatch_reg2_tag;
    new_ent.dest     = dispatch_dest_tag;
    new_ent.r1_valid = dispatch_reg1_valid || byp1_hit;
    new_ent.r1_data  = dispatch_reg1_valid ? dispatch_reg1_data : byp1_data;
    new_ent.r2_valid = dispatch_reg2_valid || byp2_hit;
    new_ent.r2_data  = dispatch_reg2_valid ? dispatch_reg2_data : byp2_data;
  end

  // Next-state for entries, pointers, occupancy and the issue stage.
  always_comb begin
    ent_d       = ent_q;
    busy_d      = busy_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_reg1_d  = out_reg1_q;
    out_reg2_d  = out_reg2_q;
    out_imm_d   = out_imm_q;
    out_dest_d  = out_dest_q;

    if (clear) begin
      busy_d      = '0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      out_valid_d = INVALID;
      out_op_d    = '0;
      out_reg1_d  = '0;
      out_reg2_d  = '0;
      out_imm_d   = '0;
      out_dest_d  = '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && !ent_q[i].r1_valid && wk1_hit[i]) begin
          ent_d[i].r1_valid = VALID;
          ent_d[i].r1_data  = wk1_data[i];
        end
        if (busy_q[i] && !ent_q[i].r2_valid && wk2_hit[i]) begin
          ent_d[i].r2_valid = VALID;
          ent_d[i].r2_data  = wk2_data[i];
        end
      end

      if (pop) begin
        busy_d[head_q] = INVALID;
        head_d         = head_q + AW'(1);
        out_valid_d    = VALID;
        out_op_d       = ent_q[head_q].op;
        out_reg1_d     = ent_q[head_q].r1_data;
        out_reg2_d     = ent_q[head_q].r2_data;
        out_imm_d      = ent_q[head_q].imm;
        out_dest_d     = ent_q[head_q].dest;
      end else if (out_ready) begin
        out_valid_d = INVALID;
        out_op_d    = '0;
        out_reg1_d  = '0;
        out_reg2_d  = '0;
        out_imm_d   = '0;
        out_dest_d  = '0;
      end

      // Written after the pop so a full-queue push can reuse the slot just vacated.
      if (push) begin
        ent_d[tail_q]  = new_ent;
        busy_d[tail_q] = VALID;
        tail_d         = tail_q + AW'(1);
      end

      case (q_action(push, pop))
        Q_PUSH:  count_d = count_q + CW'(1);
        Q_POP:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state and issue registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      busy_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= INVALID;
      out_op_q    <= '0;
      out_reg1_q  <= '0;
      out_reg2_q  <= '0;
      out_imm_q   <= '0;
      out_dest_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_reg1_q  <= out_reg1_d;
      out_reg2_q  <= out_reg2_d;
      out_imm_q   <= out_imm_d;
      out_dest_q  <= out_dest_d;
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    // NOTE: payload is not reset; busy_q gates every use, so stale contents are never observed.
    ent_q <= ent_d;
  end

  assign is_full      = (count_q == CW'(DEPTH));
  assign free_cnt     = CW'(DEPTH) - count_q;
  assign out_valid    = out_valid_q;
  assign out_op       = out_op_q;
  assign out_reg1     = out_reg1_q;
  assign out_reg2     = out_reg2_q;
  assign out_imm      = out_imm_q;
  assign out_dest_tag = out_dest_q;

endmodule

// File: tb/tb_lsb_rs_queue.sv
// Self-checking bench for lsb_rs_queue: directed scenarios plus random traffic,
// all compared every cycle against a queue-level reference model.
module tb_lsb_rs_queue;

  localparam int DEPTH   = 16;
  localparam int CDB_CNT = 4;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int OP_W    = 6;

  logic                      clk = 1'b0;
  logic                      rst, rdy, clear;
  logic                      is_full;
  logic [$clog2(DEPTH):0]    free_cnt;
  logic                      dispatch_valid;
  logic [OP_W-1:0]           dispatch_op;
  logic [DATA_W-1:0]         dispatch_imm;
  logic                      dispatch_reg1_valid;
  logic [DATA_W-1:0]         dispatch_reg1_data;
  logic [TAG_W-1:0]          dispatch_reg1_tag;
  logic                      dispatch_reg2_valid;
  logic [DATA_W-1:0]         dispatch_reg2_data;
  logic [TAG_W-1:0]          dispatch_reg2_tag;
  logic [TAG_W-1:0]          dispatch_dest_tag;
  logic [CDB_CNT-1:0]        cdb_valid;
  logic [CDB_CNT*TAG_W-1:0]  cdb_tag;
  logic [CDB_CNT*DATA_W-1:0] cdb_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [OP_W-1:0]           out_op;
  logic [DATA_W-1:0]         out_reg1, out_reg2, out_imm;
  logic [TAG_W-1:0]          out_dest_tag;

  always #5 clk = ~clk;

  lsb_rs_queue #(
    .DEPTH(DEPTH), .CDB_CNT(CDB_CNT), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .is_full(is_full), .free_cnt(free_cnt),
    .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op), .dispatch_imm(dispatch_imm),
    .dispatch_reg1_valid(dispatch_reg1_valid), .dispatch_reg1_data(dispatch_reg1_data),
    .dispatch_reg1_tag(dispatch_reg1_tag),
    .dispatch_reg2_valid(dispatch_reg2_valid), .dispatch_reg2_data(dispatch_reg2_data),
    .dispatch_reg2_tag(dispatch_reg2_tag),
    .dispatch_dest_tag(dispatch_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_reg1(out_reg1), .out_reg2(out_reg2), .out_imm(out_imm),
    .out_dest_tag(out_dest_tag)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a plain FIFO of ops plus the one-deep issue register.
  typedef struct {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm;
    bit                v1;
    logic [DATA_W-1:0] d1;
    logic [TAG_W-1:0]  t1;
    bit                v2;
    logic [DATA_W-1:0] d2;
    logic [TAG_W-1:0]  t2;
    logic [TAG_W-1:0]  dest;
  } m_ent_t;

  m_ent_t            mq[$];
  bit                m_out_v;
  logic [OP_W-1:0]   m_out_op;
  logic [DATA_W-1:0] m_out_r1, m_out_r2, m_out_imm;
  logic [TAG_W-1:0]  m_out_dest;

  function automatic bit cdb_lookup(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
    d = '0;
    for (int k = 0; k < CDB_CNT; k++) begin
      if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == t) begin
        d = cdb_data[k*DATA_W +: DATA_W];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_clear_out();
    m_out_v = 0; m_out_op = '0; m_out_r1 = '0; m_out_r2 = '0; m_out_imm = '0; m_out_dest = '0;
  endtask

  // Advance the model by one edge using the input values present at that edge.
  task automatic model_step();
    bit pop, push;
    m_ent_t ne;
    logic [DATA_W-1:0] d;
    if (!rst || clear) begin
      mq.delete();
      model_clear_out();
      return;
    end
    if (!rdy) return;
    pop  = (mq.size() > 0) && mq[0].v1 && mq[0].v2 && (!m_out_v || out_ready);
    push = dispatch_valid && ((mq.size() < DEPTH) || pop);
    if (push) begin
      ne.op = dispatch_op; ne.imm = dispatch_imm; ne.dest = dispatch_dest_tag;
      ne.v1 = dispatch_reg1_valid; ne.d1 = dispatch_reg1_data; ne.t1 = dispatch_reg1_tag;
      ne.v2 = dispatch_reg2_valid; ne.d2 = dispatch_reg2_data; ne.t2 = dispatch_reg2_tag;
      if (!ne.v1 && cdb_lookup(ne.t1, d)) begin ne.v1 = 1; ne.d1 = d; end
      if (!ne.v2 && cdb_lookup(ne.t2, d)) begin ne.v2 = 1; ne.d2 = d; end
    end
    for (int i = 0; i < mq.size(); i++) begin
      if (!mq[i].v1 && cdb_lookup(mq[i].t1, d)) begin mq[i].v1 = 1; mq[i].d1 = d; end
      if (!mq[i].v2 && cdb_lookup(mq[i].t2, d)) begin mq[i].v2 = 1; mq[i].d2 = d; end
    end
    if (pop) begin
      m_out_v = 1; m_out_op = mq[0].op; m_out_r1 = mq[0].d1; m_out_r2 = mq[0].d2;
      m_out_imm = mq[0].imm; m_out_dest = mq[0].dest;
      void'(mq.pop_front());
    end else if (out_ready) begin
      model_clear_out();
    end
    if (push) mq.push_back(ne);
  endtask

  task automatic compare_all();
    check("out_valid", 64'(out_valid), 64'(m_out_v));
    check("out_op",    64'(out_op),    64'(m_out_op));
    check("out_reg1",  64'(out_reg1),  64'(m_out_r1));
    check("out_reg2",  64'(out_reg2),  64'(m_out_r2));
    check("out_imm",   64'(out_imm),   64'(m_out_imm));
    check("out_dest",  64'(out_dest_tag), 64'(m_out_dest));
    check("is_full",   64'(is_full),   64'(mq.size() == DEPTH));
    check("free_cnt",  64'(free_cnt),  64'(DEPTH - mq.size()));
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst = 1; rdy = 1; clear = 0;
    dispatch_valid = 0; dispatch_op = '0; dispatch_imm = '0;
    dispatch_reg1_valid = 0; dispatch_reg1_data = '0; dispatch_reg1_tag = '0;
    dispatch_reg2_valid = 0; dispatch_reg2_data = '0; dispatch_reg2_tag = '0;
    dispatch_dest_tag = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic disp(input logic [DATA_W-1:0] imm, input logic v1, input logic [DATA_W-1:0] d1,
                      input logic [TAG_W-1:0] t1, input logic v2, input logic [DATA_W-1:0] d2,
                      input logic [TAG_W-1:0] dest);
    dispatch_valid = 1; dispatch_op = OP_W'(imm); dispatch_imm = imm;
    dispatch_reg1_valid = v1; dispatch_reg1_data = d1; dispatch_reg1_tag = t1;
    dispatch_reg2_valid = v2; dispatch_reg2_data = d2; dispatch_reg2_tag = '0;
    dispatch_dest_tag = dest;
  endtask

  task automatic set_cdb(input int ch, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid[ch] = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W] = t;
    cdb_data[ch*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    logic [DATA_W-1:0] last_imm;
    idle();
    out_ready = 1;
    model_clear_out();

    // Reset state.
    rst = 0;
    tick(); tick();
    check("rst_is_full", 64'(is_full), 64'd0);
    check("rst_free", 64'(free_cnt), 64'd16);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    idle();

    // Fill all 16 slots behind a pending head, then push while the head pops.
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      disp(32'h100 + DATA_W'(i), 0, '0, (i == 0) ? 4'd8 : 4'd9, 1, 32'h200 + DATA_W'(i), TAG_W'(i));
      tick();
    end
    idle();
    check("fill_full", 64'(is_full), 64'd1);
    check("fill_free", 64'(free_cnt), 64'd0);
    set_cdb(1, 4'd8, 32'h88);
    tick(); idle();
    disp(32'hCAFE, 1, 32'h5, '0, 1, 32'h6, 4'hF);
    tick(); idle();
    check("full_pp_free", 64'(free_cnt), 64'd0);
    check("full_pp_full", 64'(is_full), 64'd1);
    check("full_pp_head", 64'(out_imm), 64'h100);
    check("full_pp_reg1", 64'(out_reg1), 64'h88);
    set_cdb(3, 4'd9, 32'h99);
    tick(); idle();
    last_imm = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) last_imm = out_imm;
    end
    check("wrap_last", 64'(last_imm), 64'hCAFE);
    check("drain_free", 64'(free_cnt), 64'd16);

    // Dispatch bypass: operand broadcast on channel 2 in the dispatch cycle.
    idle();
    disp(32'h300, 0, '0, 4'd3, 1, 32'h7, 4'h1);
    set_cdb(2, 4'd3, 32'hDEADBEEF);
    tick(); idle();
    check("byp_wait", 64'(out_valid), 64'd0);
    tick();
    check("byp_valid", 64'(out_valid), 64'd1);
    check("byp_reg1", 64'(out_reg1), 64'hDEADBEEF);
    tick(); tick();

    // Blocked head holds back a ready follower; channel 0 beats channel 1.
    disp(32'h400, 0, '0, 4'd5, 1, 32'h8, 4'h2);
    tick(); idle();
    disp(32'h401, 1, 32'h9, '0, 1, 32'hA, 4'h3);
    tick(); idle();
    tick(); tick();
    check("prio_block", 64'(out_valid), 64'd0);
    set_cdb(0, 4'd5, 32'h11);
    set_cdb(1, 4'd5, 32'h22);
    tick(); idle();
    tick();
    check("prio_valid", 64'(out_valid), 64'd1);
    check("prio_reg1", 64'(out_reg1), 64'h11);
    check("prio_head", 64'(out_imm), 64'h400);
    tick();
    check("prio_second", 64'(out_imm), 64'h401);
    tick(); tick();

    // Back-pressure: output register holds, then drains with no bubble.
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      idle();
      disp(32'h500 + DATA_W'(i), 1, DATA_W'(i), '0, 1, DATA_W'(i + 10), TAG_W'(i));
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_imm", 64'(out_imm), 64'h500);
    end
    out_ready = 1;
    tick();
    check("release_1", 64'(out_imm), 64'h501);
    tick();
    check("release_2", 64'(out_imm), 64'h502);
    tick();
    check("release_idle", 64'(out_valid), 64'd0);

    // clear overrides rdy=0 and discards the pending push; then reset does the same.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++) begin
        idle();
        disp(32'h600 + DATA_W'(pass * 16 + i), 0, '0, 4'd12, 1, '0, TAG_W'(i));
        tick();
      end
      idle();
      disp(32'h6FF, 1, 32'h1, '0, 1, 32'h1, 4'h0);
      rdy = 0;
      if (pass == 0) clear = 1; else rst = 0;
      tick(); idle();
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_free", 64'(free_cnt), 64'd16);
      set_cdb(0, 4'd12, 32'h12);
      tick(); idle();
      for (int i = 0; i < 4; i++) begin
        tick();
        check("flush_no_issue", 64'(out_valid), 64'd0);
      end
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 299) != 0);
      clear = ($urandom_range(0, 99) == 0);
      rdy   = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      dispatch_valid      = ($urandom_range(0, 1) == 1);
      dispatch_op         = OP_W'($urandom);
      dispatch_imm        = $urandom;
      dispatch_reg1_valid = ($urandom_range(0, 1) == 1);
      dispatch_reg1_data  = $urandom;
      dispatch_reg1_tag   = TAG_W'($urandom_range(0, 15));
      dispatch_reg2_valid = ($urandom_range(0, 1) == 1);
      dispatch_reg2_data  = $urandom;
      dispatch_reg2_tag   = TAG_W'($urandom_range(0, 15));
      dispatch_dest_tag   = TAG_W'($urandom_range(0, 15));
      for (int k = 0; k < CDB_CNT; k++) begin
        cdb_valid[k] = ($urandom_range(0, 3) == 0);
        cdb_tag[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 15));
        cdb_data[k*DATA_W +: DATA_W] = $urandom;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
